ip_header_tx: RTL

//  IPv4 transmit framer: on a start request, builds the 20-byte IPv4 header (IHL=5, no options),

---
 rtl/ip_pkg.sv | 23 ++
 rtl/ip_csum_acc.sv | 22 ++
 rtl/ip_header_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ip_pkg.sv
// Shared IPv4 framing constants, FSM state type and ones'-complement add helper
// for the transmit framer and receive-side header checker.
package ip_pkg;

  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;
  localparam int          IP_HDR_BYTES = 20;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HDR,
    PAY
  } ip_state_t;

  // 16-bit ones'-complement add with the end-around carry folded back in
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/ip_csum_acc.sv
// 16-bit ones'-complement accumulator: clear, then one add per add_en cycle.
// Shared between the transmit framer and the receive header checker.
module ip_csum_acc
  import ip_pkg::*;
(
  input  logic        clock,
  input  logic        sclr_n,
  input  logic        clear,
  input  logic        add_en,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  always_ff @(posedge clock) begin
    if (!sclr_n || clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= ones_add(sum, word);
    end
  end

endmodule

// File: rtl/ip_header_tx.sv
// IPv4 transmit framer: builds a 20-byte header with checksum, then streams payload.
// Build option IP_HDR_ID_AUTO_EN: internal Identification counter replaces the ident port.
//
// state | meaning
// IDLE  | waiting for start; fields latched on an accepted request
// CALC  | 9 header words summed, 10th cycle stores the checksum
// HDR   | header bytes 0..19 presented, advancing on transfer
// PAY   | payload passed through combinationally until the last byte
module ip_header_tx
  import ip_pkg::*;
#(
  parameter logic [7:0] TTL         = 8'h40,
  parameter int         MAX_PAYLOAD = 1480
) (
  input  logic        clock,
  input  logic        sclr_n,
  input  logic        start,
  input  logic [15:0] payload_len,
  input  logic [15:0] ident,
  input  logic [7:0]  protocol,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic        busy,
  output logic        start_err,
  input  logic [7:0]  payload_in,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [7:0]  dataout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_sop,
  output logic        dout_eop
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
  localparam logic [4:0]  LAST_HDR = 5'(IP_HDR_BYTES - 1);

  ip_state_t   state;
  logic [3:0]  calc_cnt;
  logic [4:0]  hdr_idx;
  logic [15:0] pay_rem;
  logic [15:0] pay_len_q;
  logic [15:0] total_len_q;
  logic [15:0] ident_q;
  logic [7:0]  proto_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [15:0] csum_q;
  logic [15:0] csum_sum;
  logic [3:0]  wsel;
  logic [15:0] hdr_word;
  logic [7:0]  hdr_byte;
  logic        accept;
  logic        xfer;
`ifdef IP_HDR_ID_AUTO_EN
  logic [15:0] id_ctr;
`endif

  assign accept = (state == IDLE) && start && (payload_len <= MAX_LEN);
  assign xfer   = dout_valid && dout_ready;

  // CALC skips word 5 (the checksum slot), so calc index maps to header word index
  always_comb begin
    wsel = 4'd0;
    if (state == HDR) begin
      wsel = hdr_idx[4:1];
    end else if (calc_cnt < 4'd5) begin
      wsel = calc_cnt;
    end else begin
      wsel = calc_cnt + 4'd1;
    end
  end

  always_comb begin
    hdr_word = '0;
    case (wsel)
      4'd0:    hdr_word = {IP_VER_IHL, 8'h00};
      4'd1:    hdr_word = total_len_q;
      4'd2:    hdr_word = ident_q;
      4'd3:    hdr_word = IP_FLAGS_DF;
      4'd4:    hdr_word = {TTL, proto_q};
      4'd5:    hdr_word = csum_q;
      4'd6:    hdr_word = src_q[31:16];
      4'd7:    hdr_word = src_q[15:0];
      4'd8:    hdr_word = dst_q[31:16];
      default: hdr_word = dst_q[15:0];
    endcase
  end

  assign hdr_byte = hdr_idx[0] ? hdr_word[7:0] : hdr_word[15:8];

  ip_csum_acc u_csum (
    .clock  (clock),
    .sclr_n (sclr_n),
    .clear  (accept),
    .add_en ((state == CALC) && (calc_cnt != 4'd9)),
    .word   (hdr_word),
    .sum    (csum_sum)
  );

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      start_err <= 1'b0;
      calc_cnt  <= '0;
      hdr_idx   <= '0;
      pay_rem   <= '0;
      csum_q    <= '0;
`ifdef IP_HDR_ID_AUTO_EN
      id_ctr    <= '0;
`endif
    end else begin
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (payload_len > MAX_LEN) begin
              start_err <= 1'b1;
            end else begin
              pay_len_q   <= payload_len;
              total_len_q <= payload_len + 16'(IP_HDR_BYTES);
              proto_q     <= protocol;
              src_q       <= src_ip;
              dst_q       <= dst_ip;
`ifdef IP_HDR_ID_AUTO_EN
              ident_q     <= id_ctr;
              id_ctr      <= id_ctr + 16'd1;
`else
              ident_q     <= ident;
`endif
              calc_cnt    <= '0;
              busy        <= 1'b1;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          if (calc_cnt == 4'd9) begin
            csum_q  <= ~csum_sum;
            hdr_idx <= '0;
            state   <= HDR;
          end else begin
            calc_cnt <= calc_cnt + 4'd1;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_idx == LAST_HDR) begin
              if (pay_len_q == 16'd0) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                pay_rem <= pay_len_q;
                state   <= PAY;
              end
            end else begin
              hdr_idx <= hdr_idx + 5'd1;
            end
          end
        end
        PAY: begin
          if (xfer) begin
            pay_rem <= pay_rem - 16'd1;
            if (pay_rem == 16'd1) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dataout       = '0;
    dout_valid    = 1'b0;
    dout_sop      = 1'b0;
    dout_eop      = 1'b0;
    payload_ready = 1'b0;
    case (state)
      HDR: begin
        dataout    = hdr_byte;
        dout_valid = 1'b1;
        dout_sop   = (hdr_idx == 5'd0);
        dout_eop   = (hdr_idx == LAST_HDR) && (pay_len_q == 16'd0);
      end
      PAY: begin
        dataout       = payload_in;
        dout_valid    = payload_valid;
        payload_ready = dout_ready;
        dout_eop      = (pay_rem == 16'd1);
      end
      default: ;
    endcase
  end

endmodule
